// File: rtl/cla_chk_pkg.sv
// Shared types and layout helpers for the adder response checker.
// Checker states and default operand width.
package cla_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 2;

  // first_fail = {a, b, ci, co, sum}
  function automatic int ff_width(input int w);
    return 3 * w + 2;
  endfunction

  localparam int DEF_FF_W = 3 * DEF_WIDTH + 2;

endpackage

// File: rtl/cla_ref_adder.sv
// Golden WIDTH-bit adder with carry-in.
// Result is {co, sum}.
module cla_ref_adder
  import cla_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH:0]   res
);

  assign res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/cla_response_checker.sv
// Pipelined response checker for the adder BIST run: golden compare,
// exhaustive-order check, saturating counts, first failure and verdict.
module cla_response_checker
  import cla_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_VECTORS = 2 ** (2 * WIDTH + 1),
  parameter int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         ci,
  input  logic [WIDTH-1:0]             sum,
  input  logic                         co,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [CNT_W-1:0]             err_count,
  output logic [CNT_W-1:0]             seq_count,
  output logic                         fail_valid,
  output logic [ff_width(WIDTH)-1:0]   first_fail
);

  localparam int FW = ff_width(WIDTH);
  localparam int IW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] NVEC =
    CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t state, state_nx;
  logic   accept;
  logic   arm;

  logic [CNT_W-1:0] vec_idx;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_ci;
  logic             s1_co;
  logic [IW-1:0]    s1_idx;

  logic [WIDTH:0]   golden;

  logic             s2_valid;
  logic             s2_err;
  logic             s2_seq;
  logic [FW-1:0]    s2_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    arm      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          arm      = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        accept = in_valid;
        if (in_valid && vec_idx == LAST)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid)
          state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          arm      = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1: sample capture tagged with its expected index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx  <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sum   <= '0;
      s1_ci    <= 1'b0;
      s1_co    <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (arm)
        vec_idx <= '0;
      else if (accept && vec_idx != NVEC)
        vec_idx <= vec_idx + 1'b1;
      if (accept) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sum <= sum;
        s1_ci  <= ci;
        s1_co  <= co;
        s1_idx <= vec_idx[IW-1:0];
      end
    end
  end

  cla_ref_adder #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a   (s1_a),
    .b   (s1_b),
    .ci  (s1_ci),
    .res (golden)
  );

  // Stage 2: golden and order verdicts for one sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_seq   <= 1'b0;
      s2_vec   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err <= {s1_co, s1_sum} != golden;
        s2_seq <= {s1_a, s1_b, s1_ci} != s1_idx;
        s2_vec <= {s1_a, s1_b, s1_ci, s1_co, s1_sum};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      seq_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (arm) begin
      err_count  <= '0;
      seq_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (s2_valid) begin
      if (s2_err && err_count != CMAX)
        err_count <= err_count + 1'b1;
      if (s2_err && !fail_valid) begin
        fail_valid <= 1'b1;
        first_fail <= s2_vec;
      end
      if (s2_seq && seq_count != CMAX)
        seq_count <= seq_count + 1'b1;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0)
                     && (seq_count == '0);

endmodule

// File: tb/tb_cla_response_checker.sv
// Randomized bench for cla_response_checker against a
// vector-list reference model (WIDTH=2, 32 vectors).
module tb_cla_response_checker;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       ci;
    logic       co;
    logic [1:0] sum;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       ci = 1'b0;
  logic [1:0] sum = '0;
  logic       co = 1'b0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [5:0] seq_count;
  logic       fail_valid;
  logic [7:0] first_fail;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  vec_t vq[$];
  int   acc_t[$];
  int   exp_err[$];
  int   exp_seq[$];

  cla_response_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .ci         (ci),
    .sum        (sum),
    .co         (co),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .seq_count  (seq_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and check the live counters
  task automatic step();
    int e;
    int s;
    @(negedge clk);
    if (mon_on) begin
      e = 0;
      s = 0;
      foreach (acc_t[i])
        if (acc_t[i] + 2 <= cyc) begin
          e += exp_err[i];
          s += exp_seq[i];
        end
      check("err_live", int'(err_count), e);
      check("seq_live", int'(seq_count), s);
      if (!done) check("pass_low", int'(pass), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_seq"}, int'(seq_count), 0);
    check({tag, "_fv"}, int'(fail_valid), 0);
    check({tag, "_ff"}, int'(first_fail), 0);
  endtask

  task automatic drive_junk(input bit v);
    in_valid = v;
    {a, b, ci, sum, co} = 8'($urandom);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      drive_junk(1'b1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_on   = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Ordered vectors driven through an ideal adder
  task automatic build_ideal();
    int s;
    vec_t v;
    vq.delete();
    for (int i = 0; i < 32; i++) begin
      v.a   = 2'(i / 8);
      v.b   = 2'((i / 2) % 4);
      v.ci  = 1'(i % 2);
      s     = i / 8 + (i / 2) % 4 + i % 2;
      v.co  = 1'(s / 4);
      v.sum = 2'(s % 4);
      vq.push_back(v);
    end
  endtask

  task automatic swap(input int i);
    vec_t t;
    t       = vq[i];
    vq[i]   = vq[i + 1];
    vq[i+1] = t;
  endtask

  task automatic run(input string tag, input int gmin,
                     input int gmax, input int abort_at);
    int e, s, ff, g, r, ix, done_t;
    e  = 0;
    s  = 0;
    ff = 0;
    step();
    acc_t.delete();
    exp_err.delete();
    exp_seq.delete();
    foreach (vq[i]) begin
      g  = int'(vq[i].a) + int'(vq[i].b) + int'(vq[i].ci);
      r  = int'(vq[i].co) * 4 + int'(vq[i].sum);
      ix = int'(vq[i].a) * 8 + int'(vq[i].b) * 2
         + int'(vq[i].ci);
      exp_err.push_back(int'(r != g));
      exp_seq.push_back(int'(ix != i));
      if (r != g) begin
        if (e == 0)
          ff = int'(vq[i].a) * 64 + int'(vq[i].b) * 16
             + int'(vq[i].ci) * 8 + r;
        e++;
      end
      if (ix != i) s++;
    end
    mon_on = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    foreach (vq[i]) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        return;
      end
      repeat ($urandom_range(gmax, gmin)) begin
        drive_junk(1'b0);
        step();
      end
      in_valid = 1'b1;
      {a, b, ci, co, sum} = vq[i];
      acc_t.push_back(cyc + 1);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !done; k++) step();
    done_t = cyc;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_lat"}, done_t, acc_t[$] + 3);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_err"}, int'(err_count), e);
    check({tag, "_seq"}, int'(seq_count), s);
    check({tag, "_fv"}, int'(fail_valid), int'(e > 0));
    check({tag, "_ff"}, int'(first_fail), ff);
    check({tag, "_pass"}, int'(pass),
          int'(e == 0 && s == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check_zero("in_rst");
    rst = 1'b0;
    step();
    check_zero("post_rst");

    build_ideal();
    run("ideal", 0, 0, -1);

    build_ideal();
    vq[31].co = 1'b0;
    run("co_bad", 0, 0, -1);
    check("co_bad_ffv", int'(first_fail), 8'b11_11_1_0_11);

    build_ideal();
    swap(5);
    run("swap56", 0, 0, -1);

    do_reset();
    pulses(3);
    check_zero("idle_pulse");
    build_ideal();
    run("gap3", 2, 2, -1);
    pulses(4);
    check("gap3_done2", int'(done), 1);
    check("gap3_pass2", int'(pass), 1);

    build_ideal();
    vq[2].sum = vq[2].sum + 2'd1;
    run("abort", 0, 0, 11);
    step();
    step();
    mon_on = 1'b0;
    check("abort_err_pre", int'(err_count), 1);
    rst = 1'b1;
    #1;
    check_zero("abort_rst");
    step();
    rst = 1'b0;
    step();
    build_ideal();
    run("after_abort", 0, 0, -1);

    build_ideal();
    foreach (vq[i]) vq[i].sum = vq[i].sum + 2'd1;
    run("allbad", 0, 1, -1);
    check("allbad_ffv", int'(first_fail), 8'b00_00_0_0_01);
    mon_on = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    check("rearm_err", int'(err_count), 0);
    check("rearm_seq", int'(seq_count), 0);
    check("rearm_fv", int'(fail_valid), 0);
    check("rearm_ff", int'(first_fail), 0);
    check("rearm_busy", int'(busy), 1);
    do_reset();

    for (int it = 0; it < 4; it++) begin
      build_ideal();
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(7, 0) == 0)
          vq[i].sum = vq[i].sum + 2'($urandom_range(3, 1));
        if ($urandom_range(9, 0) == 0)
          vq[i].co = ~vq[i].co;
      end
      for (int i = 0; i < 31; i++)
        if ($urandom_range(9, 0) == 0) swap(i);
      run($sformatf("rand%0d", it), 0, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
